// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
//   state_e  : stall FSM state, doubles as the stall_cause encoding
//   ctrl_t   : per-cycle stage control bundle (MSB first: pc_stall .. ex_mem_flush)
//   ctrl_decode : prioritised request -> control mapping
package hazard_pkg;

  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned CTRL_W  = 6;

  typedef enum logic [CAUSE_W-1:0] {
    ST_RUN = 2'd0,
    ST_HAZ = 2'd1,
    ST_MDU = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

  // Priority: rst > mdu_busy > any hazard block > branch_taken.
  // A hazard hides branch_taken because the branch operands are not valid yet.
  function automatic ctrl_t ctrl_decode(input logic rst, input logic mdu,
                                        input logic hdu1, input logic hdu2,
                                        input logic br);
    ctrl_t c;
    c = '0;
    if (rst) begin
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
      c.ex_mem_flush = 1'b1;
    end else if (mdu) begin
      c.pc_stall     = 1'b1;
      c.if_id_stall  = 1'b1;
      c.id_ex_stall  = 1'b1;
      c.ex_mem_flush = 1'b1;
    end else if (hdu1 || hdu2) begin
      c.pc_stall     = 1'b1;
      c.if_id_stall  = 1'b1;
      c.id_ex_flush  = 1'b1;
    end else if (br) begin
      c.if_id_flush  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Request/control bus between the hazard sources and the stall controller.
//   master : drives requests (hdu1/hdu2/mdu/branch), observes controls and status
//   slave  : the controller; consumes requests, drives controls and status
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             hdu1_block;
  logic             hdu2_block;
  logic             mdu_busy;
  logic             branch_taken;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       stall_cause;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] bubble_count;
  logic             stall_timeout;
  logic             proto_err;

  modport master (
    output hdu1_block, hdu2_block, mdu_busy, branch_taken,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_flush, stall_cause, stall_cycles, bubble_count,
           stall_timeout, proto_err
  );

  modport slave (
    input  hdu1_block, hdu2_block, mdu_busy, branch_taken,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_flush, stall_cause, stall_cycles, bubble_count,
           stall_timeout, proto_err
  );
endinterface

// File: rtl/stall_watchdog.sv
// Consecutive-stall watchdog.
//   clk, rst      : clock, synchronous active-high reset
//   stall         : PC is held this cycle
//   stall_timeout : sticky, set once MAX_STALL consecutive stall cycles are seen
module stall_watchdog #(
  parameter int unsigned MAX_STALL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic stall_timeout
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             timeout_q, timeout_d;

  // Run length clears on any non-stall cycle and saturates at the limit.
  always_comb begin
    run_cnt_d = run_cnt_q;
    timeout_d = timeout_q;
    if (!stall) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != RUN_MAX) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
    if (run_cnt_d == RUN_MAX) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requests in (hdu1/hdu2/mdu/branch); stage controls out
//              (same-cycle), plus registered stall_cause, perf counters,
//              sticky stall_timeout and proto_err
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_STALL = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_c;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
  logic             hdu2_hist_q, hdu2_hist_d;
  logic             proto_err_q, proto_err_d;
  logic             stall_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state: the stall source seen this cycle
  always_comb begin
    state_d = ST_RUN;
    if (bus.mdu_busy)                          state_d = ST_MDU;
    else if (bus.hdu1_block || bus.hdu2_block) state_d = ST_HAZ;
  end

  // Outputs: controls are combinational from requests, cause is the state
  always_comb begin
    ctrl_c = ctrl_decode(rst, bus.mdu_busy, bus.hdu1_block, bus.hdu2_block,
                         bus.branch_taken);
  end

  assign bus.pc_stall     = ctrl_c.pc_stall;
  assign bus.if_id_stall  = ctrl_c.if_id_stall;
  assign bus.if_id_flush  = ctrl_c.if_id_flush;
  assign bus.id_ex_stall  = ctrl_c.id_ex_stall;
  assign bus.id_ex_flush  = ctrl_c.id_ex_flush;
  assign bus.ex_mem_flush = ctrl_c.ex_mem_flush;
  assign bus.stall_cause  = 2'(state_q);

  // Perf counters and load-use protocol checker
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    bubble_count_d = bubble_count_q;
    proto_err_d    = proto_err_q;
    hdu2_hist_d    = bus.hdu2_block;
    if (ctrl_c.pc_stall) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    // Reset-time flushes are not bubbles
    if ((ctrl_c.id_ex_flush || ctrl_c.ex_mem_flush) && !rst) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
    // A load-use stall must resolve in one cycle unless the MDU is holding EX
    if (hdu2_hist_q && bus.hdu2_block && !bus.mdu_busy) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
      hdu2_hist_q    <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
      hdu2_hist_q    <= hdu2_hist_d;
      proto_err_q    <= proto_err_d;
    end
  end

  stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stall         (ctrl_c.pc_stall),
    .stall_timeout (stall_timeout)
  );

  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.bubble_count  = bubble_count_q;
  assign bus.stall_timeout = stall_timeout;
  assign bus.proto_err     = proto_err_q;

endmodule
